// File: rtl/toggle_edge_gen.sv
// Toggle-signalling transmitter: each accepted event becomes one level transition on tgl_out,
// spaced at least GAP cycles apart. Optional done_pls output under TOGGLE_EDGE_GEN_DONE_EN.
module toggle_edge_gen #(
   parameter int CNT_W = 4,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evt_in,
   input  logic             ovf_clr,
   output logic             tgl_out,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
`ifdef TOGGLE_EDGE_GEN_DONE_EN
   ,
   output logic             done_pls
`endif
);

   // Handshake: evt_in is a one-cycle request with no ready; every request is accepted
   // (sent now or buffered in pending) unless pending is saturated, which drops it and sets overflow.

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] PEND_MAX  = '1;
   localparam logic [7:0]       HOLD_LOAD = 8'(GAP - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       hold_cnt;
   logic [7:0]       hold_nxt;
   logic             tgl_nxt;
   logic [CNT_W-1:0] pend_nxt;
   logic             ovf_nxt;
   logic             can_send;
   logic             send;
   logic             drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         tgl_out  <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         tgl_out  <= tgl_nxt;
         pending  <= pend_nxt;
         overflow <= ovf_nxt;
      end
   end

   always_comb begin
      can_send  = (state == IDLE) || ((state == HOLD) && (hold_cnt == 8'd0));
      send      = can_send && ((pending != '0) || evt_in);
      drop      = evt_in && !send && (pending == PEND_MAX);
      state_nxt = state;
      hold_nxt  = hold_cnt;
      tgl_nxt   = tgl_out;
      pend_nxt  = pending;
      ovf_nxt   = overflow;

      if (send) begin
         tgl_nxt   = ~tgl_out;
         hold_nxt  = HOLD_LOAD;
         state_nxt = HOLD;
         // A same-cycle request replaces the one being sent, so pending stays put.
         if (!evt_in) begin
            pend_nxt = pending - CNT_W'(1);
         end
      end else begin
         if (state == HOLD) begin
            if (hold_cnt != 8'd0) begin
               hold_nxt = hold_cnt - 8'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         if (evt_in && !drop) begin
            pend_nxt = pending + CNT_W'(1);
         end
      end

      if (ovf_clr) begin
         ovf_nxt = 1'b0;
      end
      if (drop) begin
         ovf_nxt = 1'b1;
      end
   end

   assign busy = (state == HOLD) || (pending != '0);

`ifdef TOGGLE_EDGE_GEN_DONE_EN
   logic done_nxt;

   // Leaving HOLD without a send implies pending==0, i.e. the last hold time just expired.
   always_comb begin
      done_nxt = (state == HOLD) && (hold_cnt == 8'd0) && !send;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_pls <= 1'b0;
      end else begin
         done_pls <= done_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_toggle_edge_gen.sv
// Self-checking bench for toggle_edge_gen: three instances (GAP=2/CNT_W=4, CNT_W=2, GAP=1 loopback)
// with a transition scoreboard plus directed cycle checks.
module tb_toggle_edge_gen;

   localparam int GAP_A = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       evt_a = 1'b0, ovf_clr_a = 1'b0, tgl_a, busy_a, overflow_a;
   logic [3:0] pending_a;
   logic       evt_b = 1'b0, ovf_clr_b = 1'b0, tgl_b, busy_b, overflow_b;
   logic [1:0] pending_b;
   logic       evt_c = 1'b0, ovf_clr_c = 1'b0, tgl_c, busy_c, overflow_c;
   logic [3:0] pending_c;
`ifdef TOGGLE_EDGE_GEN_DONE_EN
   logic       done_a, done_b, done_c;
`endif

   toggle_edge_gen #(.CNT_W(4), .GAP(GAP_A)) u_a (
      .clk(clk), .rst(rst), .evt_in(evt_a), .ovf_clr(ovf_clr_a), .tgl_out(tgl_a),
      .busy(busy_a), .pending(pending_a), .overflow(overflow_a)
`ifdef TOGGLE_EDGE_GEN_DONE_EN
      , .done_pls(done_a)
`endif
   );

   toggle_edge_gen #(.CNT_W(2), .GAP(2)) u_b (
      .clk(clk), .rst(rst), .evt_in(evt_b), .ovf_clr(ovf_clr_b), .tgl_out(tgl_b),
      .busy(busy_b), .pending(pending_b), .overflow(overflow_b)
`ifdef TOGGLE_EDGE_GEN_DONE_EN
      , .done_pls(done_b)
`endif
   );

   toggle_edge_gen #(.CNT_W(4), .GAP(1)) u_c (
      .clk(clk), .rst(rst), .evt_in(evt_c), .ovf_clr(ovf_clr_c), .tgl_out(tgl_c),
      .busy(busy_c), .pending(pending_c), .overflow(overflow_c)
`ifdef TOGGLE_EDGE_GEN_DONE_EN
      , .done_pls(done_c)
`endif
   );

   // Far-end either-edge detector on the GAP=1 instance.
   logic tgl_c_d;
   logic edge_c;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tgl_c_d <= 1'b0;
      else      tgl_c_d <= tgl_c;
   end
   assign edge_c = tgl_c ^ tgl_c_d;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   a_last   = -1;
   int   b_flips  = 0;
   int   c_pulses = 0;
   logic prev_a   = 1'b0;
   logic prev_b   = 1'b0;
   logic a_level  = 1'b0;
   logic c_level  = 1'b0;
   logic exp_a_q[$];
   logic exp_c_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic push_a();
      a_level = ~a_level;
      exp_a_q.push_back(a_level);
   endtask

   task automatic push_c();
      c_level = ~c_level;
      exp_c_q.push_back(c_level);
   endtask

   task automatic monitor();
      logic e;
      if (tgl_a !== prev_a) begin
         if (exp_a_q.size() == 0) begin
            check("a_unexpected_flip", 32'(tgl_a), 32'(prev_a));
         end else begin
            e = exp_a_q.pop_front();
            check("a_flip_value", 32'(tgl_a), 32'(e));
         end
         if (a_last >= 0) check("a_spacing_ok", 32'((cyc - a_last) >= GAP_A), 32'd1);
         a_last = cyc;
         prev_a = tgl_a;
      end
      if (tgl_b !== prev_b) begin
         b_flips++;
         prev_b = tgl_b;
      end
      if (edge_c) begin
         c_pulses++;
         if (exp_c_q.size() == 0) begin
            check("c_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = exp_c_q.pop_front();
            check("c_pulse_level", 32'(tgl_c), 32'(e));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   function automatic int exp_pend_b(input int c);
      case (c)
         1:       return 0;
         2, 3:    return 1;
         4, 5:    return 2;
         default: return 3;
      endcase
   endfunction

   initial begin
      logic [4:0] burst_mask;
      logic [4:0] burst_pend;
      logic       base;
      logic       found;
      int         waited;

      burst_mask = 5'b10011;
      burst_pend = 5'b01110;

      // Reset state
      #12;
      check("rst_tgl", 32'(tgl_a), 32'd0);
      check("rst_pending", 32'(pending_a), 32'd0);
      check("rst_overflow", 32'(overflow_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
`ifdef TOGGLE_EDGE_GEN_DONE_EN
      check("rst_done", 32'(done_a), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) tick();

      // Single event, GAP=2
      evt_a = 1'b1;
      push_a();
      for (int c = 1; c <= 6; c++) begin
         tick();
         evt_a = 1'b0;
         if (c == 1) check("single_tgl_c1", 32'(tgl_a), 32'd1);
         check("single_busy", 32'(busy_a), 32'(c <= 2));
         check("single_pending", 32'(pending_a), 32'd0);
`ifdef TOGGLE_EDGE_GEN_DONE_EN
         check("single_done", 32'(done_a), 32'(c == 3));
`endif
      end

      // Burst of three, GAP=2
      base = a_level;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 3) begin
            evt_a = 1'b1;
            push_a();
         end else begin
            evt_a = 1'b0;
         end
         tick();
         if (c <= 5) begin
            check("burst_tgl", 32'(tgl_a), 32'(base ^ burst_mask[c-1]));
            check("burst_pending", 32'(pending_a), 32'(burst_pend[c-1]));
         end
`ifdef TOGGLE_EDGE_GEN_DONE_EN
         if (c >= 6) check("burst_done", 32'(done_a), 32'(c == 7));
`endif
      end
      evt_a = 1'b0;

      // Random spacing on A, drained through the scoreboard
      for (int i = 0; i < 12; i++) begin
         evt_a = 1'b1;
         push_a();
         tick();
         evt_a = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      waited = 0;
      while (busy_a && waited < 200) begin
         tick();
         waited++;
      end
      check("rand_drain_timeout", 32'(busy_a), 32'd0);
      check("rand_pending_end", 32'(pending_a), 32'd0);
      check("rand_queue_empty", 32'(exp_a_q.size()), 32'd0);
      check("rand_no_overflow", 32'(overflow_a), 32'd0);

      // Overflow, CNT_W=2, GAP=2
      b_flips = 0;
      for (int c = 1; c <= 16; c++) begin
         evt_b     = (c - 1) <= 9;
         ovf_clr_b = (c - 1) == 12;
         tick();
         if (c <= 10) check("ovf_pending", 32'(pending_b), 32'(exp_pend_b(c)));
         if (c == 7)  check("ovf_before_drop", 32'(overflow_b), 32'd0);
         if (c == 8)  check("ovf_set", 32'(overflow_b), 32'd1);
         if (c == 12) check("ovf_sticky", 32'(overflow_b), 32'd1);
         if (c == 13) check("ovf_cleared", 32'(overflow_b), 32'd0);
      end
      evt_b     = 1'b0;
      ovf_clr_b = 1'b0;
      waited = 0;
      while (busy_b && waited < 100) begin
         tick();
         waited++;
      end
      check("ovf_drain_timeout", 32'(busy_b), 32'd0);
      check("ovf_transitions", 32'(b_flips), 32'd8);

      // Loopback, GAP=1: one edge pulse per event
      c_pulses = 0;
      for (int i = 0; i < 7; i++) begin
         evt_c = 1'b1;
         push_c();
         tick();
         evt_c = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (5) tick();
      check("loop_pulse_count", 32'(c_pulses), 32'd7);
      check("loop_queue_empty", 32'(exp_c_q.size()), 32'd0);
      check("loop_pending", 32'(pending_c), 32'd0);

      // Reset mid-burst once pending reaches 3
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         evt_a = 1'b1;
         push_a();
         tick();
         if (pending_a == 4'd3) found = 1'b1;
      end
      evt_a = 1'b0;
      check("mid_pending3_reached", 32'(found), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_tgl", 32'(tgl_a), 32'd0);
      check("mid_rst_pending", 32'(pending_a), 32'd0);
      check("mid_rst_overflow", 32'(overflow_a), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      exp_a_q.delete();
      exp_c_q.delete();
      a_level = 1'b0;
      c_level = 1'b0;
      prev_a  = 1'b0;
      prev_b  = 1'b0;
      a_last  = -1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) tick();
      check("post_rst_tgl", 32'(tgl_a), 32'd0);
      check("post_rst_pending", 32'(pending_a), 32'd0);
      check("post_rst_busy", 32'(busy_a), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
